// File: rtl/minisys_io_pkg.sv
// ============================================================================
// minisys_io_pkg : shared encodings for the switch input MMIO block
// Revision 1.0
// ============================================================================
`default_nettype none

package minisys_io_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_READ    = 2'd1,
      WAIT_RELEASE = 2'd2
   } state_t;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_RAW    = 2'd2;

   localparam int STAT_VALID   = 0;
   localparam int STAT_ENTER   = 1;
   localparam int STAT_SW_LSB  = 2;
   localparam int STAT_OVERRUN = 5;

endpackage

`default_nettype wire

// File: rtl/sw_debounce.sv
// ============================================================================
// sw_debounce : two-flop synchroniser followed by a whole-vector debouncer
// Revision 1.0
// ============================================================================
`default_nettype none

module sw_debounce #(
   parameter int WIDTH           = 24,
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_sw,
   output logic [WIDTH-1:0] o_stable
);

   localparam int            CW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] C_CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] r_stable;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_next;

   // Counter saturates at the acceptance threshold, so a quiet input keeps
   // reloading the same value into r_stable.
   always_comb begin
      w_cnt_next = r_cnt;
      if (r_sync2 != r_prev) begin
         w_cnt_next = '0;
      end else if (r_cnt != C_CNT_MAX) begin
         w_cnt_next = r_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_prev   <= '0;
         r_stable <= '0;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= i_sw;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         r_cnt   <= w_cnt_next;
         if (w_cnt_next == C_CNT_MAX) begin
            r_stable <= r_sync2;
         end
      end
   end

   assign o_stable = r_stable;

endmodule

`default_nettype wire

// File: rtl/switch_input_ctrl.sv
// ============================================================================
// switch_input_ctrl : debounced board switches exposed as CPU MMIO registers
// Revision 1.0
// ============================================================================
`default_nettype none

module switch_input_ctrl
   import minisys_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int ENTER_BIT       = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [23:0] sw,
   input  logic        io_rd,
   input  logic [1:0]  io_addr,
   output logic [31:0] io_rdata,
   output logic        io_rvalid,
   output logic        wait_led
);

   logic [23:0] w_stable;
   logic        w_enter;
   logic        w_rise;
   logic        w_rd_data;
   logic        w_rd_status;

   state_t      r_state;
   state_t      w_state_next;
   logic        r_enter_d;
   logic [15:0] r_data;
   logic        r_valid;
   logic        r_ovr;
   logic [31:0] r_rdata;
   logic        r_rvalid;

   logic        w_load;
   logic        w_valid_clr;
   logic        w_ovr_set;
   logic [31:0] w_status;
   logic [31:0] w_rd_mux;

   sw_debounce #(
      .WIDTH           (24),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_sw     (sw),
      .o_stable (w_stable)
   );

   assign w_enter     = w_stable[ENTER_BIT];
   assign w_rise      = w_enter & ~r_enter_d;
   assign w_rd_data   = io_rd && (io_addr == ADDR_DATA);
   assign w_rd_status = io_rd && (io_addr == ADDR_STATUS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // A DATA read in WAIT_READ takes precedence over a coincident press.
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_valid_clr  = 1'b0;
      w_ovr_set    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_rise) begin
               w_load       = 1'b1;
               w_state_next = WAIT_READ;
            end
         end
         WAIT_READ: begin
            if (w_rd_data) begin
               w_valid_clr  = 1'b1;
               w_state_next = w_enter ? WAIT_RELEASE : IDLE;
            end else if (w_rise) begin
               w_ovr_set = 1'b1;
            end
         end
         WAIT_RELEASE: begin
            if (!w_enter) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      w_status                        = '0;
      w_status[STAT_VALID]            = r_valid;
      w_status[STAT_ENTER]            = w_enter;
      w_status[STAT_SW_LSB +: 3]      = w_stable[23:21];
      w_status[STAT_OVERRUN]          = r_ovr;
   end

   always_comb begin
      w_rd_mux = '0;
      case (io_addr)
         ADDR_DATA:   w_rd_mux = {16'h0, r_data};
         ADDR_STATUS: w_rd_mux = w_status;
         ADDR_RAW:    w_rd_mux = {8'h0, w_stable};
         default:     w_rd_mux = '0;
      endcase
   end

   // Set wins over the read-clear so an overrun coinciding with a STATUS read
   // is still visible on the next read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_enter_d <= 1'b0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_ovr     <= 1'b0;
         r_rdata   <= '0;
         r_rvalid  <= 1'b0;
      end else begin
         r_enter_d <= w_enter;
         if (w_load) begin
            r_data  <= w_stable[15:0];
            r_valid <= 1'b1;
         end else if (w_valid_clr) begin
            r_valid <= 1'b0;
         end
         if (w_ovr_set) begin
            r_ovr <= 1'b1;
         end else if (w_rd_status) begin
            r_ovr <= 1'b0;
         end
         r_rvalid <= io_rd;
         r_rdata  <= io_rd ? w_rd_mux : 32'h0;
      end
   end

   assign io_rdata  = r_rdata;
   assign io_rvalid = r_rvalid;
   assign wait_led  = (r_state == IDLE);

endmodule

`default_nettype wire

// File: tb/tb_switch_input_ctrl.sv
// ============================================================================
// tb_switch_input_ctrl : scenario and randomized checks against an event model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_switch_input_ctrl;

   localparam int HOLD   = 1100;
   localparam int ENTER  = 20;
   localparam int M_IDLE = 0;
   localparam int M_READ = 1;
   localparam int M_REL  = 2;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic [23:0] sw      = '0;
   logic        io_rd   = 1'b0;
   logic [1:0]  io_addr = '0;
   logic [31:0] io_rdata;
   logic        io_rvalid;
   logic        wait_led;

   int n_vec  = 0;
   int n_err  = 0;
   int rv_bad = 0;

   // Event-level model: the switch vector is only ever seen once it has settled.
   int          m_state;
   logic [23:0] m_stable;
   logic [15:0] m_data;
   logic        m_valid;
   logic        m_ovr;

   switch_input_ctrl #(
      .DEBOUNCE_CYCLES (1000),
      .ENTER_BIT       (ENTER)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sw        (sw),
      .io_rd     (io_rd),
      .io_addr   (io_addr),
      .io_rdata  (io_rdata),
      .io_rvalid (io_rvalid),
      .wait_led  (wait_led)
   );

   always #5 clk = ~clk;

   // Response strobe must follow the request strobe by exactly one cycle.
   always @(posedge clk) begin
      logic exp_rv;
      exp_rv = io_rd & rst_n;
      #1;
      if (io_rvalid !== exp_rv) rv_bad++;
   end

   task automatic model_reset();
      m_state  = M_IDLE;
      m_stable = '0;
      m_data   = '0;
      m_valid  = 1'b0;
      m_ovr    = 1'b0;
   endtask

   task automatic model_set_sw(input logic [23:0] v);
      logic was;
      was      = m_stable[ENTER];
      m_stable = v;
      if (!was && v[ENTER]) begin
         if (m_state == M_IDLE) begin
            m_data  = v[15:0];
            m_valid = 1'b1;
            m_state = M_READ;
         end else if (m_state == M_READ) begin
            m_ovr = 1'b1;
         end
      end
      if (!v[ENTER] && m_state == M_REL) m_state = M_IDLE;
   endtask

   task automatic model_read(input logic [1:0] a, output logic [31:0] e);
      case (a)
         2'd0: begin
            e = {16'h0, m_data};
            if (m_state == M_READ) begin
               m_valid = 1'b0;
               m_state = m_stable[ENTER] ? M_REL : M_IDLE;
            end
         end
         2'd1: begin
            e     = {26'h0, m_ovr, m_stable[23:21], m_stable[ENTER], m_valid};
            m_ovr = 1'b0;
         end
         2'd2:    e = {8'h0, m_stable};
         default: e = 32'h0;
      endcase
   endtask

   task automatic apply_sw(input logic [23:0] v);
      @(posedge clk); #1 sw = v;
      repeat (HOLD) @(posedge clk);
      #1;
      model_set_sw(v);
   endtask

   task automatic glitch_enter(input int toggles);
      @(posedge clk); #1;
      for (int i = 0; i < toggles; i++) begin
         sw[ENTER] = ~sw[ENTER];
         repeat (10) @(posedge clk);
         #1;
      end
   endtask

   task automatic do_read(input logic [1:0] a, output logic rv, output logic [31:0] d);
      @(posedge clk); #1 io_rd = 1'b1; io_addr = a;
      @(posedge clk); #1 io_rd = 1'b0;
      rv = io_rvalid;
      d  = io_rdata;
   endtask

   task automatic test_reset();
      logic rv; logic [31:0] d, e;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (io_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", io_rdata); end
      n_vec++; if (io_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b expected 0", io_rvalid); end
      n_vec++; if (wait_led !== 1'b1) begin n_err++; $display("FAIL reset_led: got %b expected 1", wait_led); end
      @(negedge clk) rst_n = 1'b1;
      model_reset();
      do_read(2'd1, rv, d); model_read(2'd1, e);
      n_vec++; if (rv !== 1'b1 || d !== e) begin n_err++; $display("FAIL reset_status: got rv=%b %h expected rv=1 %h", rv, d, e); end
   endtask

   task automatic test_basic();
      logic rv; logic [31:0] d, e;
      apply_sw(24'h000001);
      n_vec++; if (wait_led !== 1'b1) begin n_err++; $display("FAIL basic_idle_led: got %b expected 1", wait_led); end
      apply_sw(24'h100001);
      n_vec++; if (wait_led !== 1'b0) begin n_err++; $display("FAIL basic_led: got %b expected 0", wait_led); end
      do_read(2'd1, rv, d); model_read(2'd1, e);
      n_vec++; if (rv !== 1'b1 || d !== e || d[0] !== 1'b1) begin n_err++; $display("FAIL basic_status: got rv=%b %h expected rv=1 %h", rv, d, e); end
      do_read(2'd0, rv, d); model_read(2'd0, e);
      n_vec++; if (rv !== 1'b1 || d !== 32'h1) begin n_err++; $display("FAIL basic_data: got rv=%b %h expected rv=1 00000001", rv, d); end
      apply_sw(24'h000001);
      n_vec++; if (wait_led !== (m_state == M_IDLE)) begin n_err++; $display("FAIL basic_release_led: got %b expected %b", wait_led, m_state == M_IDLE); end
   endtask

   task automatic test_glitch();
      logic rv; logic [31:0] d, e;
      @(posedge clk); #1 sw = 24'h0000A5;
      glitch_enter(50);
      apply_sw(24'h1000A5);
      do_read(2'd1, rv, d); model_read(2'd1, e);
      n_vec++; if (rv !== 1'b1 || d !== e || d[5] !== 1'b0) begin n_err++; $display("FAIL glitch_status: got rv=%b %h expected rv=1 %h", rv, d, e); end
      do_read(2'd0, rv, d); model_read(2'd0, e);
      n_vec++; if (rv !== 1'b1 || d !== e) begin n_err++; $display("FAIL glitch_data: got rv=%b %h expected rv=1 %h", rv, d, e); end
      apply_sw(24'h0);
   endtask

   task automatic test_overrun();
      logic rv; logic [31:0] d, e;
      apply_sw(24'h101234);
      apply_sw(24'h001234);
      apply_sw(24'h105678);
      do_read(2'd1, rv, d); model_read(2'd1, e);
      n_vec++; if (rv !== 1'b1 || d !== e || d[5] !== 1'b1) begin n_err++; $display("FAIL ovr_status1: got rv=%b %h expected rv=1 %h", rv, d, e); end
      do_read(2'd0, rv, d); model_read(2'd0, e);
      n_vec++; if (rv !== 1'b1 || d !== 32'h1234) begin n_err++; $display("FAIL ovr_data: got rv=%b %h expected rv=1 00001234", rv, d); end
      do_read(2'd1, rv, d); model_read(2'd1, e);
      n_vec++; if (rv !== 1'b1 || d !== e || d[5] !== 1'b0) begin n_err++; $display("FAIL ovr_status2: got rv=%b %h expected rv=1 %h", rv, d, e); end
      apply_sw(24'h0);
   endtask

   task automatic test_hold_release();
      logic rv; logic [31:0] d, e;
      apply_sw(24'h10BEEF);
      do_read(2'd0, rv, d); model_read(2'd0, e);
      n_vec++; if (rv !== 1'b1 || d !== e) begin n_err++; $display("FAIL hold_data: got rv=%b %h expected rv=1 %h", rv, d, e); end
      glitch_enter(2);
      apply_sw(24'h10CAFE);
      n_vec++; if (wait_led !== 1'b0) begin n_err++; $display("FAIL hold_led: got %b expected 0", wait_led); end
      do_read(2'd1, rv, d); model_read(2'd1, e);
      n_vec++; if (rv !== 1'b1 || d !== e) begin n_err++; $display("FAIL hold_status: got rv=%b %h expected rv=1 %h", rv, d, e); end
      apply_sw(24'h00CAFE);
      n_vec++; if (wait_led !== 1'b1) begin n_err++; $display("FAIL release_led: got %b expected 1", wait_led); end
      do_read(2'd0, rv, d); model_read(2'd0, e);
      n_vec++; if (rv !== 1'b1 || d !== 32'hBEEF) begin n_err++; $display("FAIL release_data: got rv=%b %h expected rv=1 0000beef", rv, d); end
   endtask

   task automatic test_status_bits();
      logic rv; logic [31:0] d, e;
      apply_sw(24'hB00042);
      do_read(2'd1, rv, d); model_read(2'd1, e);
      n_vec++; if (rv !== 1'b1 || d !== e || d[4:2] !== 3'b101) begin n_err++; $display("FAIL status_bits: got rv=%b %h expected rv=1 %h", rv, d, e); end
      do_read(2'd2, rv, d); model_read(2'd2, e);
      n_vec++; if (rv !== 1'b1 || d !== e) begin n_err++; $display("FAIL raw: got rv=%b %h expected rv=1 %h", rv, d, e); end
      do_read(2'd0, rv, d); model_read(2'd0, e);
      apply_sw(24'h0);
   endtask

   task automatic test_overrun_vs_status();
      logic rv; logic [31:0] d, e;
      int hits;
      apply_sw(24'h100011);
      apply_sw(24'h000011);
      do_read(2'd1, rv, d); model_read(2'd1, e);
      n_vec++; if (rv !== 1'b1 || d !== e) begin n_err++; $display("FAIL poll_pre: got rv=%b %h expected rv=1 %h", rv, d, e); end
      hits = 0;
      @(posedge clk); #1 sw = 24'h100022; io_rd = 1'b1; io_addr = 2'd1;
      repeat (HOLD) begin
         @(posedge clk); #1;
         if (io_rvalid && io_rdata[5]) hits++;
      end
      io_rd = 1'b0;
      model_set_sw(24'h100022);
      m_ovr = 1'b0;
      n_vec++; if (hits != 1) begin n_err++; $display("FAIL poll_overrun_hits: got %0d expected 1", hits); end
      do_read(2'd0, rv, d); model_read(2'd0, e);
      n_vec++; if (rv !== 1'b1 || d !== 32'h11) begin n_err++; $display("FAIL poll_data: got rv=%b %h expected rv=1 00000011", rv, d); end
      apply_sw(24'h0);
   endtask

   task automatic test_random();
      logic rv; logic [31:0] d, e;
      logic [23:0] v;
      logic [1:0]  a;
      for (int i = 0; i < 12; i++) begin
         v        = 24'($urandom);
         v[ENTER] = 1'($urandom_range(0, 1));
         apply_sw(v);
         n_vec++; if (wait_led !== (m_state == M_IDLE)) begin n_err++; $display("FAIL rand_led[%0d]: got %b expected %b", i, wait_led, m_state == M_IDLE); end
         a = 2'($urandom_range(0, 3));
         do_read(a, rv, d); model_read(a, e);
         n_vec++; if (rv !== 1'b1 || d !== e) begin n_err++; $display("FAIL rand_read[%0d] addr %0d: got rv=%b %h expected rv=1 %h", i, a, rv, d, e); end
      end
      apply_sw(24'h0);
      do_read(2'd0, rv, d); model_read(2'd0, e);
      do_read(2'd1, rv, d); model_read(2'd1, e);
   endtask

   task automatic test_reset_mid();
      logic rv; logic [31:0] d, e;
      apply_sw(24'h107777);
      @(posedge clk); #1 io_rd = 1'b1; io_addr = 2'd0;
      @(posedge clk); #1 io_rd = 1'b0;
      @(negedge clk) rst_n = 1'b0;
      #1;
      n_vec++; if (io_rvalid !== 1'b0) begin n_err++; $display("FAIL mid_rvalid: got %b expected 0", io_rvalid); end
      n_vec++; if (io_rdata !== 32'h0) begin n_err++; $display("FAIL mid_rdata: got %h expected 0", io_rdata); end
      n_vec++; if (wait_led !== 1'b1) begin n_err++; $display("FAIL mid_led: got %b expected 1", wait_led); end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      model_reset();
      @(posedge clk); #1;
      n_vec++; if (io_rvalid !== 1'b0) begin n_err++; $display("FAIL mid_no_resp: got %b expected 0", io_rvalid); end
      repeat (HOLD) @(posedge clk);
      #1;
      model_set_sw(sw);
      n_vec++; if (wait_led !== 1'b0) begin n_err++; $display("FAIL held_press_led: got %b expected 0", wait_led); end
      do_read(2'd1, rv, d); model_read(2'd1, e);
      n_vec++; if (rv !== 1'b1 || d !== e) begin n_err++; $display("FAIL held_press_status: got rv=%b %h expected rv=1 %h", rv, d, e); end
      do_read(2'd0, rv, d); model_read(2'd0, e);
      n_vec++; if (rv !== 1'b1 || d !== 32'h7777) begin n_err++; $display("FAIL held_press_data: got rv=%b %h expected rv=1 00007777", rv, d); end
      apply_sw(24'h0);
   endtask

   task automatic test_rvalid_protocol();
      n_vec++; if (rv_bad != 0) begin n_err++; $display("FAIL rvalid_timing: got %0d bad cycles expected 0", rv_bad); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_glitch();
      test_overrun();
      test_hold_release();
      test_status_bits();
      test_overrun_vs_status();
      test_random();
      test_reset_mid();
      test_rvalid_protocol();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
